// File: rtl/joydb9_pkg.sv
// joydb9_pkg: shared FSM states and default DB9 button bit mapping
package joydb9_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, HIGH, LOW, DONE} state_t;
  localparam int unsigned J_UP    = 0;
  localparam int unsigned J_DOWN  = 1;
  localparam int unsigned J_LEFT  = 2;
  localparam int unsigned J_RIGHT = 3;
  localparam int unsigned J_FIRE1 = 4;
  localparam int unsigned J_FIRE2 = 5;
  localparam int unsigned J_FIRE3 = 6;
  localparam int unsigned J_START = 7;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser with configurable reset value
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/joydb9_serial_reader.sv
// joydb9_serial_reader: drives a 74HC165-style chain and deserialises two joystick button words
module joydb9_serial_reader
  import joydb9_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int NUM_BITS = 16,
  parameter int SCAN_GAP = 1000
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  scan_en,
  input  logic                  joy_data,
  output logic                  joy_clk,
  output logic                  joy_load,
  output logic [NUM_BITS/2-1:0] joy1,
  output logic [NUM_BITS/2-1:0] joy2,
  output logic                  frame_valid
);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam int GW = $clog2(SCAN_GAP + 1);
  localparam int H  = NUM_BITS / 2;
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [H-1:0] joy1_q, joy1_d, joy2_q, joy2_d;
  logic joy_clk_q, joy_clk_d, joy_load_q, joy_load_d, frame_valid_q, frame_valid_d;
  logic data_s, last, gap_full, last_bit;
  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_sys(clk_sys),
    .reset  (reset),
    .d      (joy_data),
    .q      (data_s)
  );
  always_comb begin
    last      = phase_q == PW'(CLK_DIV - 1);
    gap_full  = gap_q == GW'(SCAN_GAP - 1);
    last_bit  = bit_cnt_q == BW'(NUM_BITS - 1);
    state_d   = state_q;
    phase_d   = (state_q == IDLE || state_q == DONE || last) ? '0 : phase_q + PW'(1);
    bit_cnt_d = bit_cnt_q;
    gap_d     = gap_q;
    sr_d      = sr_q;
    case (state_q)
      IDLE: begin
        gap_d   = gap_full ? gap_q : gap_q + GW'(1);
        state_d = (gap_full && scan_en) ? LOAD : IDLE;
      end
      LOAD:   state_d = last ? SETTLE : LOAD;
      SETTLE: if (last) begin
        sr_d      = {sr_q[NUM_BITS-2:0], data_s};
        bit_cnt_d = BW'(1);
        state_d   = HIGH;
      end
      HIGH:   state_d = last ? LOW : HIGH;
      LOW:    if (last) begin
        sr_d      = {sr_q[NUM_BITS-2:0], data_s};
        bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
        state_d   = last_bit ? DONE : HIGH;
      end
      DONE: begin
        gap_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    joy1_d        = state_d == DONE ? ~sr_d[NUM_BITS-1:H] : joy1_q;
    joy2_d        = state_d == DONE ? ~sr_d[H-1:0] : joy2_q;
    joy_clk_d     = state_d == HIGH;
    joy_load_d    = state_d != LOAD;
    frame_valid_d = state_d == DONE;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      bit_cnt_q     <= '0;
      gap_q         <= '0;
      sr_q          <= '0;
      joy1_q        <= '0;
      joy2_q        <= '0;
      joy_clk_q     <= 1'b0;
      joy_load_q    <= 1'b1;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_q         <= gap_d;
      sr_q          <= sr_d;
      joy1_q        <= joy1_d;
      joy2_q        <= joy2_d;
      joy_clk_q     <= joy_clk_d;
      joy_load_q    <= joy_load_d;
      frame_valid_q <= frame_valid_d;
    end
  end
  assign joy_clk     = joy_clk_q;
  assign joy_load    = joy_load_q;
  assign joy1        = joy1_q;
  assign joy2        = joy2_q;
  assign frame_valid = frame_valid_q;
endmodule
